// File: rtl/superh16_pkg.sv
// Shared execute-cluster types: ALU opcodes, ALU result payload, and the
// ROB age comparator that is also used by the LSU and branch unit.
package superh16_pkg;

    localparam int PKG_XLEN          = 64;
    localparam int PKG_PHYS_REG_BITS = 7;
    localparam int PKG_ROB_IDX_BITS  = 5;

    localparam logic [7:0] ALU_EXC_ILLEGAL = 8'h02;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } uop_opcode_t;

    typedef struct packed {
        logic [PKG_XLEN-1:0]          result;
        logic [PKG_PHYS_REG_BITS-1:0] dst_tag;
        logic [PKG_ROB_IDX_BITS-1:0]  rob_idx;
        logic                         exception;
        logic [7:0]                   exception_code;
    } alu_payload_t;

    // Distances from the ROB head are compared so that index wrap-around is handled.
    function automatic logic rob_is_younger(
        input logic [PKG_ROB_IDX_BITS-1:0] x,
        input logic [PKG_ROB_IDX_BITS-1:0] f,
        input logic [PKG_ROB_IDX_BITS-1:0] head
    );
        logic [PKG_ROB_IDX_BITS-1:0] dist_x;
        logic [PKG_ROB_IDX_BITS-1:0] dist_f;
        dist_x = x - head;
        dist_f = f - head;
        return dist_x > dist_f;
    endfunction

endpackage

// File: rtl/superh16_alu_slot.sv
// One valid/ready pipeline register slot carrying an ALU payload; a kill
// empties an occupied slot unless its payload is leaving this cycle.
module superh16_alu_slot
    import superh16_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  alu_payload_t in_data,
    output logic         up_ready,
    input  logic         kill,
    input  logic         down_ready,
    output logic         out_valid,
    output alu_payload_t out_data
);

    logic         valid_r;
    alu_payload_t data_r;
    logic         advance_s;

    assign advance_s = !valid_r || down_ready;
    assign up_ready  = advance_s;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Slot state: load on advance, hold while stalled, drop on kill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (advance_s) begin
            valid_r <= in_valid;
            if (in_valid) begin
                data_r <= in_data;
            end
        end else if (kill) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/superh16_int_alu_pipe.sv
// Integer ALU with configurable result latency: combinational compute feeding
// a chain of STAGES handshake slots, with ROB-age squash on mispredict.
module superh16_int_alu_pipe
    import superh16_pkg::*;
#(
    parameter int XLEN          = PKG_XLEN,
    parameter int STAGES        = 1,
    parameter int WORD_OPS      = 1,
    parameter int PHYS_REG_BITS = PKG_PHYS_REG_BITS,
    parameter int ROB_IDX_BITS  = PKG_ROB_IDX_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  uop_opcode_t              in_opcode,
    input  logic                     in_word,
    input  logic [XLEN-1:0]          in_src1,
    input  logic [XLEN-1:0]          in_src2,
    input  logic [PHYS_REG_BITS-1:0] in_dst_tag,
    input  logic [ROB_IDX_BITS-1:0]  in_rob_idx,
    input  logic [ROB_IDX_BITS-1:0]  rob_head,
    input  logic                     flush_valid,
    input  logic [ROB_IDX_BITS-1:0]  flush_rob_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_result,
    output logic [PHYS_REG_BITS-1:0] out_dst_tag,
    output logic [ROB_IDX_BITS-1:0]  out_rob_idx,
    output logic                     out_exception,
    output logic [7:0]               out_exception_code
);

    localparam int SHAMT_BITS = $clog2(XLEN);

    logic             word_mode_s;
    logic             illegal_s;
    logic [31:0]      word_res_s;
    logic [XLEN-1:0]  full_res_s;
    logic             in_kill_s;
    alu_payload_t     comp_s;

    assign word_mode_s = (WORD_OPS != 0) && in_word;
    assign in_kill_s   = flush_valid && rob_is_younger(in_rob_idx, flush_rob_idx, rob_head);

    // Opcode decode and arithmetic for both the full-width and the word forms
    always_comb begin
        illegal_s  = 1'b0;
        word_res_s = 32'h0;
        full_res_s = '0;
        if (word_mode_s) begin
            case (in_opcode)
                OP_ADD:  word_res_s = in_src1[31:0] + in_src2[31:0];
                OP_SUB:  word_res_s = in_src1[31:0] - in_src2[31:0];
                OP_SLL:  word_res_s = in_src1[31:0] << in_src2[4:0];
                OP_SRL:  word_res_s = in_src1[31:0] >> in_src2[4:0];
                OP_SRA:  word_res_s = $unsigned($signed(in_src1[31:0]) >>> in_src2[4:0]);
                default: illegal_s  = 1'b1;
            endcase
            full_res_s = XLEN'($signed(word_res_s));
        end else begin
            case (in_opcode)
                OP_ADD:  full_res_s = in_src1 + in_src2;
                OP_SUB:  full_res_s = in_src1 - in_src2;
                OP_AND:  full_res_s = in_src1 & in_src2;
                OP_OR:   full_res_s = in_src1 | in_src2;
                OP_XOR:  full_res_s = in_src1 ^ in_src2;
                OP_SLL:  full_res_s = in_src1 << in_src2[SHAMT_BITS-1:0];
                OP_SRL:  full_res_s = in_src1 >> in_src2[SHAMT_BITS-1:0];
                OP_SRA:  full_res_s = $unsigned($signed(in_src1) >>> in_src2[SHAMT_BITS-1:0]);
                OP_SLT:  full_res_s = {{(XLEN-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
                OP_SLTU: full_res_s = {{(XLEN-1){1'b0}}, (in_src1 < in_src2)};
                default: illegal_s  = 1'b1;
            endcase
        end
    end

    // Illegal uops still travel down the pipe, carrying a zero result and the cause
    always_comb begin
        comp_s         = '0;
        comp_s.dst_tag = in_dst_tag;
        comp_s.rob_idx = in_rob_idx;
        if (illegal_s) begin
            comp_s.result         = '0;
            comp_s.exception      = 1'b1;
            comp_s.exception_code = ALU_EXC_ILLEGAL;
        end else begin
            comp_s.result         = full_res_s;
            comp_s.exception      = 1'b0;
            comp_s.exception_code = 8'h00;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        logic         up_valid_s;
        alu_payload_t up_data_s;
        logic         down_ready_s;
        logic         ready_s;
        logic         valid_s;
        logic         kill_s;
        alu_payload_t data_s;

        // A payload killed in this slot must not be handed to the next one
        if (k == 0) begin : g_first
            assign up_valid_s = in_valid && !in_kill_s;
            assign up_data_s  = comp_s;
        end else begin : g_next
            assign up_valid_s = g_slot[k-1].valid_s && !g_slot[k-1].kill_s;
            assign up_data_s  = g_slot[k-1].data_s;
        end

        if (k == STAGES - 1) begin : g_last
            assign down_ready_s = out_ready;
        end else begin : g_mid
            assign down_ready_s = g_slot[k+1].ready_s;
        end

        assign kill_s = flush_valid && rob_is_younger(data_s.rob_idx, flush_rob_idx, rob_head);

        superh16_alu_slot u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (up_valid_s),
            .in_data    (up_data_s),
            .up_ready   (ready_s),
            .kill       (kill_s),
            .down_ready (down_ready_s),
            .out_valid  (valid_s),
            .out_data   (data_s)
        );
    end

    assign in_ready           = g_slot[0].ready_s;
    assign out_valid          = g_slot[STAGES-1].valid_s;
    assign out_result         = g_slot[STAGES-1].data_s.result;
    assign out_dst_tag        = g_slot[STAGES-1].data_s.dst_tag;
    assign out_rob_idx        = g_slot[STAGES-1].data_s.rob_idx;
    assign out_exception      = g_slot[STAGES-1].data_s.exception;
    assign out_exception_code = g_slot[STAGES-1].data_s.exception_code;

endmodule

// File: tb/tb_superh16_int_alu_pipe.sv
// Bench: two ALU pipes (2 and 3 stages) checked against an in-order queue
// model of handed-off results, plus directed literal expectations.
module tb_superh16_int_alu_pipe;
    import superh16_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic [6:0]  dst;
        logic [4:0]  rob;
        logic        exc;
        logic [7:0]  code;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    uop_opcode_t in_opcode = OP_ADD;
    logic        in_word = 1'b0;
    logic [63:0] in_src1 = 64'd0;
    logic [63:0] in_src2 = 64'd0;
    logic [6:0]  in_dst_tag = 7'd0;
    logic [4:0]  in_rob_idx = 5'd0;
    logic [4:0]  rob_head = 5'd0;
    logic        flush_valid = 1'b0;
    logic [4:0]  flush_rob_idx = 5'd0;

    logic        in_valid [2];
    logic        out_ready [2];
    logic        in_ready [2];
    logic        out_valid [2];
    logic [63:0] out_result [2];
    logic [6:0]  out_dst_tag [2];
    logic [4:0]  out_rob_idx [2];
    logic        out_exception [2];
    logic [7:0]  out_exception_code [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    superh16_int_alu_pipe #(.STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_opcode(in_opcode), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2),
        .in_dst_tag(in_dst_tag), .in_rob_idx(in_rob_idx), .rob_head(rob_head),
        .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(out_result[0]),
        .out_dst_tag(out_dst_tag[0]), .out_rob_idx(out_rob_idx[0]),
        .out_exception(out_exception[0]), .out_exception_code(out_exception_code[0])
    );

    superh16_int_alu_pipe #(.STAGES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_opcode(in_opcode), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2),
        .in_dst_tag(in_dst_tag), .in_rob_idx(in_rob_idx), .rob_head(rob_head),
        .flush_valid(flush_valid), .flush_rob_idx(flush_rob_idx),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(out_result[1]),
        .out_dst_tag(out_dst_tag[1]), .out_rob_idx(out_rob_idx[1]),
        .out_exception(out_exception[1]), .out_exception_code(out_exception_code[1])
    );

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic bit younger(input int x, input int f, input int h);
        return ((x - h + 32) % 32) > ((f - h + 32) % 32);
    endfunction

    function automatic exp_t model(input uop_opcode_t op, input logic w, input logic [63:0] a,
                                   input logic [63:0] b, input logic [4:0] rob, input logic [6:0] dst);
        exp_t        e;
        int          x, y, r;
        logic [31:0] ux;
        longint      sa, sb;
        e.rob = rob; e.dst = dst; e.exc = 1'b0; e.code = 8'h00; e.result = 64'd0;
        r = 0;
        if (w) begin
            x = int'(a[31:0]); y = int'(b[31:0]); ux = a[31:0];
            case (op)
                OP_ADD:  r = x + y;
                OP_SUB:  r = x - y;
                OP_SLL:  r = x << b[4:0];
                OP_SRL:  r = int'(ux >> b[4:0]);
                OP_SRA:  r = x >>> b[4:0];
                default: e.exc = 1'b1;
            endcase
            if (!e.exc) e.result = 64'(longint'(r));
        end else begin
            sa = longint'(a); sb = longint'(b);
            case (op)
                OP_ADD:  e.result = a + b;
                OP_SUB:  e.result = a - b;
                OP_AND:  e.result = a & b;
                OP_OR:   e.result = a | b;
                OP_XOR:  e.result = a ^ b;
                OP_SLL:  e.result = a << b[5:0];
                OP_SRL:  e.result = a >> b[5:0];
                OP_SRA:  e.result = 64'(sa >>> b[5:0]);
                OP_SLT:  e.result = (sa < sb) ? 64'd1 : 64'd0;
                OP_SLTU: e.result = (a < b) ? 64'd1 : 64'd0;
                default: e.exc = 1'b1;
            endcase
        end
        if (e.exc) e.code = 8'h02;
        return e;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_mon
        exp_t expq[$];
        exp_t logq[$];
        // Inputs and outputs are settled at the falling edge; apply what the next rising edge does
        always @(negedge clk) begin
            exp_t e, got;
            if (!rst_n) begin
                expq.delete();
            end else begin
                if (out_valid[d] && out_ready[d]) begin
                    got.result = out_result[d]; got.dst = out_dst_tag[d]; got.rob = out_rob_idx[d];
                    got.exc = out_exception[d]; got.code = out_exception_code[d];
                    logq.push_back(got);
                    if (expq.size() == 0) begin
                        check64($sformatf("spurious_out%0d", d), 64'(got.rob), 64'hDEAD);
                    end else begin
                        e = expq.pop_front();
                        check64($sformatf("rob%0d", d), 64'(got.rob), 64'(e.rob));
                        check64($sformatf("result%0d", d), got.result, e.result);
                        check64($sformatf("dst%0d", d), 64'(got.dst), 64'(e.dst));
                        check64($sformatf("exc%0d", d), {55'd0, got.exc, got.code}, {55'd0, e.exc, e.code});
                    end
                end
                if (flush_valid) begin
                    for (int i = expq.size() - 1; i >= 0; i--)
                        if (younger(int'(expq[i].rob), int'(flush_rob_idx), int'(rob_head))) expq.delete(i);
                end
                if (in_valid[d] && in_ready[d] &&
                    !(flush_valid && younger(int'(in_rob_idx), int'(flush_rob_idx), int'(rob_head))))
                    expq.push_back(model(in_opcode, in_word, in_src1, in_src2, in_rob_idx, in_dst_tag));
            end
        end
    end

    task automatic send(input int d, input uop_opcode_t op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rob);
        bit acc;
        acc = 1'b0;
        in_opcode = op; in_word = w; in_src1 = a; in_src2 = b;
        in_rob_idx = rob; in_dst_tag = 7'(rob * 3);
        in_valid[d] = 1'b1;
        for (int c = 0; c < 40 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready[d];
        end
        check64("send_accept", 64'(acc), 64'd1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic stage_uop(input int i);
        in_opcode = OP_ADD; in_word = 1'b0;
        in_src1 = 64'(1000 + i); in_src2 = 64'(i);
        in_rob_idx = 5'(10 + i); in_dst_tag = 7'((10 + i) * 3);
        in_valid[1] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, sent;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        out_ready[0] = 1'b1; out_ready[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check64("rst_out_valid_a", 64'(out_valid[0]), 64'd0);
        check64("rst_out_valid_b", 64'(out_valid[1]), 64'd0);
        check64("rst_out_result_b", out_result[1], 64'd0);
        check64("rst_out_exc_b", {55'd0, out_exception[1], out_exception_code[1]}, 64'd0);
        check64("rst_in_ready_a", 64'(in_ready[0]), 64'd1);
        check64("rst_in_ready_b", 64'(in_ready[1]), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency of two stages and back-to-back throughput
        send(0, OP_ADD, 1'b0, 64'd5, 64'd7, 5'd1);
        send(0, OP_SUB, 1'b0, 64'd3, 64'd5, 5'd2);
        @(negedge clk);
        check64("lat_add_valid", 64'(out_valid[0]), 64'd1);
        check64("lat_add_result", out_result[0], 64'd12);
        check64("lat_in_ready", 64'(in_ready[0]), 64'd1);
        @(negedge clk);
        check64("lat_sub_result", out_result[0], 64'hFFFF_FFFF_FFFF_FFFE);

        // Word mode and illegal opcodes
        repeat (4) @(posedge clk); #1;
        base = g_mon[0].logq.size();
        send(0, OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1, 5'd3);
        send(0, OP_SRA, 1'b1, 64'h8000_0000, 64'd4, 5'd4);
        send(0, OP_SLL, 1'b1, 64'd1, 64'd33, 5'd5);
        send(0, OP_XOR, 1'b1, 64'hFF, 64'h0F, 5'd6);
        send(0, OP_SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd7);
        send(0, OP_SLL, 1'b0, 64'd1, 64'd65, 5'd8);
        send(0, uop_opcode_t'(4'd12), 1'b0, 64'd9, 64'd9, 5'd9);
        send(0, OP_SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4, 5'd10);
        send(0, OP_AND, 1'b0, 64'hF0F0, 64'hFF00, 5'd11);
        send(0, OP_SLTU, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12);
        repeat (5) @(posedge clk); #1;
        check64("word_count", 64'(g_mon[0].logq.size()), 64'(base + 10));
        if (g_mon[0].logq.size() >= base + 10) begin
            check64("word_add", g_mon[0].logq[base].result, 64'hFFFF_FFFF_8000_0000);
            check64("word_sra", g_mon[0].logq[base+1].result, 64'hFFFF_FFFF_F800_0000);
            check64("word_sll33", g_mon[0].logq[base+2].result, 64'd2);
            check64("word_xor_res", g_mon[0].logq[base+3].result, 64'd0);
            check64("word_xor_exc", {55'd0, g_mon[0].logq[base+3].exc, g_mon[0].logq[base+3].code}, 64'h102);
            check64("sra64", g_mon[0].logq[base+4].result, 64'hF800_0000_0000_0000);
            check64("sll65", g_mon[0].logq[base+5].result, 64'd2);
            check64("illegal_exc", {55'd0, g_mon[0].logq[base+6].exc, g_mon[0].logq[base+6].code}, 64'h102);
            check64("word_srl", g_mon[0].logq[base+7].result, 64'h0000_0000_0800_0000);
            check64("and64", g_mon[0].logq[base+8].result, 64'hF000);
            check64("sltu64", g_mon[0].logq[base+9].result, 64'd1);
        end

        // Backpressure on the three-stage pipe
        base = g_mon[1].logq.size();
        out_ready[1] = 1'b0; sent = 0;
        stage_uop(0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (in_valid[1] && in_ready[1]) sent++;
            @(posedge clk); #1;
            if (sent < 6) stage_uop(sent); else in_valid[1] = 1'b0;
        end
        check64("bp_accepts", 64'(sent), 64'd3);
        check64("bp_in_ready", 64'(in_ready[1]), 64'd0);
        check64("bp_hold_result", out_result[1], 64'd1000);
        check64("bp_hold_rob", 64'(out_rob_idx[1]), 64'd10);
        out_ready[1] = 1'b1;
        for (int c = 0; c < 30 && sent < 6; c++) begin
            @(negedge clk);
            if (in_valid[1] && in_ready[1]) sent++;
            @(posedge clk); #1;
            if (sent < 6) stage_uop(sent); else in_valid[1] = 1'b0;
        end
        in_valid[1] = 1'b0;
        repeat (6) @(posedge clk); #1;
        check64("bp_count", 64'(g_mon[1].logq.size()), 64'(base + 6));
        for (int i = 0; i < 6 && base + i < g_mon[1].logq.size(); i++) begin
            check64("bp_order", 64'(g_mon[1].logq[base+i].rob), 64'(10 + i));
            check64("bp_value", g_mon[1].logq[base+i].result, 64'(1000 + 2 * i));
        end

        // Flush across the ROB index wrap
        rob_head = 5'd30; out_ready[1] = 1'b0;
        base = g_mon[1].logq.size();
        send(1, OP_ADD, 1'b0, 64'd31, 64'd0, 5'd31);
        send(1, OP_SUB, 1'b0, 64'd0, 64'd1, 5'd0);
        send(1, OP_OR, 1'b0, 64'd2, 64'd4, 5'd2);
        flush_valid = 1'b1; flush_rob_idx = 5'd0;
        @(posedge clk); #1;
        flush_valid = 1'b0;
        check64("flush_keep_valid", 64'(out_valid[1]), 64'd1);
        check64("flush_keep_rob", 64'(out_rob_idx[1]), 64'd31);
        out_ready[1] = 1'b1;
        repeat (6) @(posedge clk); #1;
        check64("flush_count", 64'(g_mon[1].logq.size()), 64'(base + 2));
        if (g_mon[1].logq.size() >= base + 2) begin
            check64("flush_first", 64'(g_mon[1].logq[base].rob), 64'd31);
            check64("flush_second", 64'(g_mon[1].logq[base+1].rob), 64'd0);
            check64("flush_wrap_res", g_mon[1].logq[base+1].result, 64'hFFFF_FFFF_FFFF_FFFF);
        end

        // Flush of a stalled final slot, with a younger uop arriving alongside
        rob_head = 5'd0; out_ready[1] = 1'b0;
        base = g_mon[1].logq.size();
        send(1, OP_ADD, 1'b0, 64'd1, 64'd1, 5'd5);
        repeat (2) @(posedge clk); #1;
        check64("stall_valid", 64'(out_valid[1]), 64'd1);
        flush_valid = 1'b1; flush_rob_idx = 5'd2;
        in_opcode = OP_ADD; in_word = 1'b0; in_rob_idx = 5'd6; in_dst_tag = 7'd18;
        in_valid[1] = 1'b1;
        check64("flush_in_ready", 64'(in_ready[1]), 64'd1);
        @(posedge clk); #1;
        flush_valid = 1'b0; in_valid[1] = 1'b0;
        check64("stall_flush_valid", 64'(out_valid[1]), 64'd0);
        out_ready[1] = 1'b1;
        repeat (5) @(posedge clk); #1;
        check64("stall_flush_count", 64'(g_mon[1].logq.size()), 64'(base));

        // Reset in the middle of a stream
        base = g_mon[1].logq.size();
        send(1, OP_ADD, 1'b0, 64'd1, 64'd1, 5'd1);
        send(1, OP_ADD, 1'b0, 64'd2, 64'd2, 5'd2);
        send(1, OP_ADD, 1'b0, 64'd3, 64'd3, 5'd3);
        check64("pre_rst_valid", 64'(out_valid[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        check64("mid_rst_valid", 64'(out_valid[1]), 64'd0);
        check64("mid_rst_result", out_result[1], 64'd0);
        check64("mid_rst_in_ready", 64'(in_ready[1]), 64'd1);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        check64("post_rst_in_ready", 64'(in_ready[1]), 64'd1);
        send(1, OP_SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7);
        send(1, OP_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd8);
        repeat (6) @(posedge clk); #1;
        check64("post_rst_count", 64'(g_mon[1].logq.size()), 64'(base + 2));
        if (g_mon[1].logq.size() >= base + 2) begin
            check64("post_rst_slt", g_mon[1].logq[base].result, 64'd1);
            check64("post_rst_sltu", g_mon[1].logq[base+1].result, 64'd0);
            check64("post_rst_rob", 64'(g_mon[1].logq[base].rob), 64'd7);
        end

        check64("drain_a", 64'(g_mon[0].expq.size()), 64'd0);
        check64("drain_b", 64'(g_mon[1].expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
